// File: rtl/bram_rd_pkg.sv
// rtl/bram_rd_pkg.sv - shared constants and FSM encoding for the BRAM stream reader
package bram_rd_pkg;

    localparam int DEF_DWIDTH   = 32;
    localparam int DEF_AWIDTH   = 12;
    localparam int DEF_MEM_SIZE = 3840;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/bram_stream_reader_if.sv
// rtl/bram_stream_reader_if.sv - output word stream of the BRAM stream reader
interface bram_stream_reader_if #(
    parameter int DWIDTH = 32
);
    logic              m_valid_o;
    logic [DWIDTH-1:0] m_data_o;
    logic              m_last_o;
    logic              m_ready_i;

    modport master (
        output m_valid_o,
        output m_data_o,
        output m_last_o,
        input  m_ready_i
    );

    modport slave (
        input  m_valid_o,
        input  m_data_o,
        input  m_last_o,
        output m_ready_i
    );
endinterface

// File: rtl/fifo2_skid.sv
// rtl/fifo2_skid.sv - two-entry output buffer holding {last, data}
module fifo2_skid #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         do_push, do_pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        do_pop   = pop && (cnt_q != 2'd0);
        // A full buffer still accepts a word in the same cycle it releases one
        do_push  = push && ((cnt_q != 2'd2) || do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        cnt_d = cnt_q + 2'(do_push) - 2'(do_pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = cnt_q;

endmodule

// File: rtl/bram_stream_reader.sv
// rtl/bram_stream_reader.sv - reads a run of BRAM words and streams them out with backpressure
module bram_stream_reader
    import bram_rd_pkg::*;
#(
    parameter int DWIDTH   = DEF_DWIDTH,
    parameter int AWIDTH   = DEF_AWIDTH,
    parameter int MEM_SIZE = DEF_MEM_SIZE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic [AWIDTH-1:0] base_addr_i,
    input  logic [AWIDTH-1:0] len_i,
    output logic [AWIDTH-1:0] addr_o,
    output logic              ce_o,
    output logic              we_o,
    input  logic [DWIDTH-1:0] q_i,
    bram_stream_reader_if.master m,
    output logic              busy_o,
    output logic              done_o
);

    state_e            state_q, state_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [AWIDTH-1:0] issue_left_q, issue_left_d;
    logic              inflight_q, inflight_d;
    logic              inflight_last_q, inflight_last_d;
    logic              done_q, done_d;

    logic [AWIDTH-1:0] len_eff;
    logic              issue;
    logic              pop;
    logic              out_valid;
    logic [2:0]        occ;
    logic [1:0]        fifo_cnt;
    logic [DWIDTH:0]   fifo_head;

    assign out_valid = (fifo_cnt != 2'd0);
    assign pop       = out_valid && m.m_ready_i;
    assign len_eff   = (len_i > AWIDTH'(MEM_SIZE)) ? AWIDTH'(MEM_SIZE) : len_i;

    // Words already buffered or on their way, after this cycle's departure
    assign occ = 3'(fifo_cnt) + 3'(inflight_q) - 3'(pop);

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        issue_left_d    = issue_left_q;
        inflight_d      = 1'b0;
        inflight_last_d = 1'b0;
        done_d          = 1'b0;
        issue           = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    addr_d       = base_addr_i;
                    issue_left_d = len_eff;
                    if (len_eff == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (occ < 3'd2) begin
                    issue           = 1'b1;
                    inflight_d      = 1'b1;
                    inflight_last_d = (issue_left_q == AWIDTH'(1));
                    issue_left_d    = issue_left_q - AWIDTH'(1);
                    addr_d          = (addr_q == AWIDTH'(MEM_SIZE - 1)) ? '0 : addr_q + AWIDTH'(1);
                    if (issue_left_q == AWIDTH'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && fifo_head[DWIDTH]) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            addr_q          <= '0;
            issue_left_q    <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            issue_left_q    <= issue_left_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            done_q          <= done_d;
        end
    end

    fifo2_skid #(
        .W(DWIDTH + 1)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight_q),
        .push_data ({inflight_last_q, q_i}),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_cnt)
    );

    assign addr_o      = addr_q;
    assign ce_o        = issue;
    assign we_o        = 1'b0;
    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = done_q;
    assign m.m_valid_o = out_valid;
    assign m.m_data_o  = out_valid ? fifo_head[DWIDTH-1:0] : '0;
    assign m.m_last_o  = out_valid && fifo_head[DWIDTH];

endmodule

// File: tb/tb_bram_stream_reader.sv
// tb/tb_bram_stream_reader.sv - randomized scoreboard bench for bram_stream_reader
module tb_bram_stream_reader;
    localparam int DW = 32;
    localparam int AW = 12;
    localparam int MS = 3840;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start_i = 1'b0;
    logic [AW-1:0] base_addr_i = '0;
    logic [AW-1:0] len_i = '0;
    logic [AW-1:0] addr_o;
    logic          ce_o, we_o, busy_o, done_o;
    logic [DW-1:0] q_i = '0;

    bram_stream_reader_if #(.DWIDTH(DW)) s ();

    bram_stream_reader #(.DWIDTH(DW), .AWIDTH(AW), .MEM_SIZE(MS)) dut (
        .clk         (clk),
        .reset       (reset),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .len_i       (len_i),
        .addr_o      (addr_o),
        .ce_o        (ce_o),
        .we_o        (we_o),
        .q_i         (q_i),
        .m           (s),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [MS];
    initial for (int i = 0; i < MS; i++) mem[i] = DW'(i);

    always @(posedge clk) if (ce_o) q_i <= mem[int'(addr_o) % MS];

    int checks = 0;
    int errors = 0;

    task automatic check(input bit ok, input string name, input longint act, input longint req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference model state
    logic [DW:0] exp_word_q[$];
    int          exp_addr_q[$];
    bit          model_busy = 0;
    bit          done_exp = 0;
    int          out_cnt = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          words = 0;
    bit          lat_mode = 0;
    bit          cmd_lat = 0;
    bit          ready_rand = 0;
    bit          prev_stall = 0;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    initial begin
        s.m_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1 s.m_ready_i = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            exp_word_q.delete();
            exp_addr_q.delete();
            model_busy = 0;
            done_exp   = 0;
            out_cnt    = 0;
            prev_stall = 0;
            words      = 0;
        end else begin
            automatic bit xfer = s.m_valid_o && s.m_ready_i;
            automatic bit exp_ce;
            cyc++;
            check(we_o == 1'b0, "we_o", we_o, 0);
            check(busy_o == model_busy, "busy_o", busy_o, model_busy);
            check(done_o == done_exp, "done_o", done_o, done_exp);
            exp_ce = (exp_addr_q.size() > 0) && ((out_cnt - int'(xfer)) < 2);
            check(ce_o == exp_ce, "ce_o", ce_o, exp_ce);
            if (ce_o && exp_addr_q.size() > 0) begin
                automatic int a = exp_addr_q.pop_front();
                check(int'(addr_o) == a, "addr_o", addr_o, a);
            end
            out_cnt += int'(ce_o) - int'(xfer);
            check(out_cnt <= 2 && out_cnt >= 0, "occupancy", out_cnt, 2);
            if (prev_stall)
                check(s.m_valid_o && s.m_data_o == prev_data && s.m_last_o == prev_last,
                      "stall_hold", {s.m_last_o, s.m_data_o}, {prev_last, prev_data});
            prev_stall = s.m_valid_o && !s.m_ready_i;
            prev_data  = s.m_data_o;
            prev_last  = s.m_last_o;
            done_exp   = 0;
            if (xfer) begin
                if (exp_word_q.size() == 0) begin
                    check(0, "unexpected_word", s.m_data_o, -1);
                end else begin
                    automatic logic [DW:0] e = exp_word_q.pop_front();
                    check(s.m_data_o == e[DW-1:0], "m_data_o", s.m_data_o, e[DW-1:0]);
                    check(s.m_last_o == e[DW], "m_last_o", s.m_last_o, e[DW]);
                    if (cmd_lat)
                        check(cyc == start_cyc + 3 + words, "latency", cyc - start_cyc, 3 + words);
                    words++;
                    if (e[DW]) begin
                        model_busy = 0;
                        done_exp   = 1;
                    end
                end
            end
            if (start_i && !model_busy) begin
                automatic int n = (int'(len_i) > MS) ? MS : int'(len_i);
                if (n == 0) begin
                    done_exp = 1;
                end else begin
                    model_busy = 1;
                    start_cyc  = cyc;
                    words      = 0;
                    cmd_lat    = lat_mode;
                    for (int k = 0; k < n; k++) begin
                        automatic int a = (int'(base_addr_i) + k) % MS;
                        exp_addr_q.push_back(a);
                        exp_word_q.push_back({(k == n - 1), mem[a]});
                    end
                end
            end
        end
    end

    task automatic start_cmd(input int base, input int len, input bit rnd);
        @(posedge clk);
        #1;
        ready_rand  = rnd;
        lat_mode    = !rnd;
        start_i     = 1'b1;
        base_addr_i = AW'(base);
        len_i       = AW'(len);
        @(posedge clk);
        #1 start_i = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int i;
        for (i = 0; i < bound; i++) begin
            @(posedge clk);
            if (!model_busy && exp_word_q.size() == 0) break;
        end
        if (i == bound) check(0, "timeout", i, bound);
        repeat (3) @(posedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({ce_o, we_o, busy_o, done_o, s.m_valid_o, s.m_last_o} == 6'b0, {tag, "_flags"},
              {ce_o, we_o, busy_o, done_o, s.m_valid_o, s.m_last_o}, 0);
        check(addr_o == '0, {tag, "_addr"}, addr_o, 0);
        check(s.m_data_o == '0, {tag, "_data"}, s.m_data_o, 0);
    endtask

    initial begin
        #3 check_outputs_zero("reset");
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        start_cmd(0, 4, 0);
        wait_idle(50);
        start_cmd(3838, 4, 0);
        wait_idle(50);
        start_cmd(17, 8, 1);
        wait_idle(200);
        start_cmd(9, 0, 0);
        wait_idle(20);

        // Second command arrives while the first is still running
        start_cmd(200, 100, 0);
        repeat (3) @(posedge clk);
        start_cmd(7, 5, 0);
        wait_idle(300);

        start_cmd(40, 10, 0);
        for (int i = 0; i < 100 && words < 3; i++) @(posedge clk);
        #2 reset = 1'b1;
        #1 check_outputs_zero("midreset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        start_cmd(5, 2, 0);
        wait_idle(50);

        start_cmd(100, 4095, 0);
        wait_idle(5000);

        for (int r = 0; r < 8; r++) begin
            start_cmd(int'($urandom_range(0, MS - 1)), int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)));
            wait_idle(300);
        end

        check(exp_word_q.size() == 0, "leftover_words", exp_word_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
